// File: rtl/fabric_config_loader_if.sv
// Serial configuration handshake between a bitstream source and the fabric loader.
interface fabric_config_loader_if;
    logic cfg_start;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;

    modport master (output cfg_start, output cfg_bit, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_start, input cfg_bit, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Serial fabric configuration loader: sync byte check, payload shift into a shadow
// register, even-parity check, and an atomic commit to the fabric-facing words.
module fabric_config_loader #(
    parameter int          NUM_TILES = 6,
    parameter int          NUM_SB    = 2,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    fabric_config_loader_if.slave    cfg,
    output logic [NUM_TILES*33-1:0]  tile_cfg,
    output logic [NUM_SB*16-1:0]     sb_cfg,
    output logic                     cfg_done,
    output logic                     cfg_error,
    output logic                     fabric_en
);
    localparam int TILE_BITS = NUM_TILES * 33;
    localparam int P         = TILE_BITS + NUM_SB * 16;
    localparam int CNT_W     = $clog2(P);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

    typedef enum logic [2:0] {IDLE, SYNC_ST, LOAD, PARITY, DONE, ERROR} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             parity_acc;
    logic [P-1:0]     shadow;
    logic             ready_q;
    logic             accept;
    logic             start;
    logic             sync_bit;
    logic             parity_ok;

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;
    assign start         = cfg.cfg_start &&
                           ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign sync_bit      = SYNC[3'd7 - cnt[2:0]];
    assign parity_ok     = (parity_acc ^ cfg.cfg_bit) == 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = SYNC_ST;
            SYNC_ST: begin
                if (accept) begin
                    if (cfg.cfg_bit != sync_bit) next_state = ERROR;
                    else if (cnt[2:0] == 3'd7)   next_state = LOAD;
                end
            end
            LOAD:    if (accept && cnt == LAST) next_state = PARITY;
            PARITY:  if (accept) next_state = parity_ok ? DONE : ERROR;
            default: next_state = IDLE;
        endcase
    end

    // Ready is registered from the next state so it never follows cfg_valid combinationally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            cnt        <= '0;
            parity_acc <= 1'b0;
            shadow     <= '0;
            tile_cfg   <= '0;
            sb_cfg     <= '0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            fabric_en  <= 1'b0;
        end else begin
            ready_q <= (next_state == SYNC_ST) || (next_state == LOAD) ||
                       (next_state == PARITY);
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        cnt        <= '0;
                        parity_acc <= 1'b0;
                        shadow     <= '0;
                        cfg_done   <= 1'b0;
                        cfg_error  <= 1'b0;
                        fabric_en  <= 1'b0;
                    end
                end
                SYNC_ST: begin
                    if (accept) begin
                        if (cfg.cfg_bit != sync_bit) cfg_error <= 1'b1;
                        else if (cnt[2:0] == 3'd7)   cnt       <= '0;
                        else                         cnt       <= cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow[cnt] <= cfg.cfg_bit;
                        parity_acc  <= parity_acc ^ cfg.cfg_bit;
                        cnt         <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    // Fabric words change only here, so a bad frame never disturbs them.
                    if (accept) begin
                        if (parity_ok) begin
                            tile_cfg  <= shadow[TILE_BITS-1:0];
                            sb_cfg    <= shadow[P-1:TILE_BITS];
                            cfg_done  <= 1'b1;
                            fabric_en <= 1'b1;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: good, bad-sync, bad-parity, stalled,
// reset-mid-load and start-pulse frames against hand-computed words.
module tb_fabric_config_loader;
    localparam int FRAME = 239;

    logic         clock;
    logic         reset_n;
    logic [197:0] tile_cfg;
    logic [31:0]  sb_cfg;
    logic         cfg_done, cfg_error, fabric_en;
    int           tests_run = 0;
    int           tests_failed = 0;
    int           frame_cycles;

    logic [197:0] good_tiles;
    logic [197:0] bad_tiles;
    logic [31:0]  good_sb;
    logic [238:0] frame;

    fabric_config_loader_if cfg_if ();

    fabric_config_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg       (cfg_if),
        .tile_cfg  (tile_cfg),
        .sb_cfg    (sb_cfg),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .fabric_en (fabric_en)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bit k of the frame is the k-th bit on the wire.
    task automatic buildFrame(input logic [197:0] tiles, input logic [31:0] sbs,
                              input bit flip, output logic [238:0] fr);
        logic [229:0] payload;
        logic [7:0]   sync_byte;
        sync_byte = 8'hA5;
        payload   = {sbs, tiles};
        fr        = '0;
        for (int k = 0; k < 8; k++)   fr[k]     = sync_byte[7-k];
        for (int k = 0; k < 230; k++) fr[8 + k] = payload[k];
        fr[238] = (^payload) ^ flip;
    endtask

    task automatic startLoad();
        @(negedge clock);
        cfg_if.cfg_start = 1'b1;
    endtask

    // Returns at the negedge after the edge that accepted the last bit.
    task automatic applyStimulus(input logic [238:0] fr, input int nbits,
                                 input bit stall, input int pulse_idx);
        int i;
        int cycles;
        i      = 0;
        cycles = 0;
        while (i < nbits && cycles < 3000) begin
            @(negedge clock);
            cycles++;
            cfg_if.cfg_start = (i == pulse_idx);
            cfg_if.cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_if.cfg_bit   = fr[i];
            if (cfg_if.cfg_valid && cfg_if.cfg_ready) i++;
        end
        @(negedge clock);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_start = 1'b0;
        frame_cycles = cycles;
        if (i < nbits) checkOutput("bit_budget", 256'(i), 256'(nbits));
    endtask

    initial begin
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_bit   = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        reset_n          = 1'b0;
        good_tiles = 198'h1_0000_8001;
        bad_tiles  = good_tiles | (198'h0_DEAD_BEEF << 33);
        good_sb    = 32'h1248_8421;

        #22 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_tile", 256'(tile_cfg), 256'(0));
        checkOutput("rst_sb", 256'(sb_cfg), 256'(0));
        checkOutput("rst_flags", 256'({cfg_done, cfg_error, fabric_en}), 256'(0));
        checkOutput("rst_ready", 256'(cfg_if.cfg_ready), 256'(0));

        // Good frame with valid held high
        buildFrame(good_tiles, good_sb, 1'b0, frame);
        startLoad();
        applyStimulus(frame, FRAME, 1'b0, -1);
        checkOutput("good_latency", 256'(frame_cycles), 256'(239));
        checkOutput("good_tile0", 256'(tile_cfg[32:0]), 256'(33'h1_0000_8001));
        checkOutput("good_tiles", 256'(tile_cfg), 256'(good_tiles));
        checkOutput("good_sb", 256'(sb_cfg), 256'(32'h1248_8421));
        checkOutput("good_flags", 256'({cfg_done, cfg_error, fabric_en}), 256'(3'b101));
        checkOutput("good_ready", 256'(cfg_if.cfg_ready), 256'(0));

        // Reset after 50 payload bits
        startLoad();
        applyStimulus(frame, 58, 1'b0, -1);
        checkOutput("midload_ready", 256'(cfg_if.cfg_ready), 256'(1));
        checkOutput("midload_hold", 256'(tile_cfg), 256'(good_tiles));
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_tile", 256'(tile_cfg), 256'(0));
        checkOutput("arst_sb", 256'(sb_cfg), 256'(0));
        checkOutput("arst_flags", 256'({cfg_done, cfg_error, fabric_en, cfg_if.cfg_ready}),
                    256'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("arst_idle_ready", 256'(cfg_if.cfg_ready), 256'(0));

        // Fresh good load, then a bad sync byte
        startLoad();
        applyStimulus(frame, FRAME, 1'b0, -1);
        checkOutput("reload_done", 256'(cfg_done), 256'(1));
        for (int k = 0; k < 8; k++) frame[k] = 1'b0;
        frame[7:0] = 8'b0010_0101;  // A4 sent MSB first: bits 1,0,1,0,0,1,0,0
        startLoad();
        applyStimulus(frame, 8, 1'b0, -1);
        checkOutput("badsync_flags", 256'({cfg_done, cfg_error, fabric_en, cfg_if.cfg_ready}),
                    256'(4'b0100));
        checkOutput("badsync_tile", 256'(tile_cfg), 256'(good_tiles));
        checkOutput("badsync_sb", 256'(sb_cfg), 256'(32'h1248_8421));

        // Changed payload with flipped parity
        buildFrame(bad_tiles, good_sb, 1'b1, frame);
        startLoad();
        applyStimulus(frame, FRAME, 1'b0, -1);
        checkOutput("parity_flags", 256'({cfg_done, cfg_error, fabric_en}), 256'(3'b010));
        checkOutput("parity_tile", 256'(tile_cfg), 256'(good_tiles));
        checkOutput("parity_sb", 256'(sb_cfg), 256'(32'h1248_8421));
        checkOutput("error_ready", 256'(cfg_if.cfg_ready), 256'(0));

        // Stalled stream
        buildFrame(good_tiles, good_sb, 1'b0, frame);
        startLoad();
        applyStimulus(frame, FRAME, 1'b1, -1);
        checkOutput("stall_tiles", 256'(tile_cfg), 256'(good_tiles));
        checkOutput("stall_sb", 256'(sb_cfg), 256'(32'h1248_8421));
        checkOutput("stall_flags", 256'({cfg_done, cfg_error, fabric_en, cfg_if.cfg_ready}),
                    256'(4'b1010));

        // Start pulse at payload bit 100 is ignored
        startLoad();
        applyStimulus(frame, FRAME, 1'b0, 108);
        checkOutput("pulse_latency", 256'(frame_cycles), 256'(239));
        checkOutput("pulse_tiles", 256'(tile_cfg), 256'(good_tiles));
        checkOutput("pulse_flags", 256'({cfg_done, cfg_error, fabric_en}), 256'(3'b101));

        // Start in DONE re-enters SYNC
        startLoad();
        @(negedge clock);
        cfg_if.cfg_start = 1'b0;
        checkOutput("restart_flags", 256'({cfg_done, cfg_error, fabric_en, cfg_if.cfg_ready}),
                    256'(4'b0001));
        checkOutput("restart_tiles", 256'(tile_cfg), 256'(good_tiles));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
